// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end for one shared signed-amount barrel shifter.
// Two requesters compete for the shifter. The winner's operands are captured in
// registers that feed the shifter. The shifter result is registered and returned
// on a single response channel, tagged with the id of the requester that issued it.
//
// Handshake semantics (all three channels):
//   A transfer happens on a rising edge where valid && ready are both high and
//   rst is low. A source holds valid, data and amt stable until that edge. ready
//   may depend combinationally on valid. valid never depends on ready. On a reset
//   cycle no transfer occurs on any channel.
module shift_arbiter #(
  parameter int WIDTH      = 16,
  parameter int AMT_W      = 5,
  parameter int FIRST_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic [WIDTH-1:0] sh_ain,
  output logic [AMT_W-1:0] sh_bin,
  input  logic [WIDTH-1:0] sh_yout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // state_q is the observable FSM state for checkers and debug.
  state_t           state_q;
  state_t           state_d;
  logic             prio_q;
  logic             id_q;
  logic [WIDTH-1:0] op_q;
  logic [AMT_W-1:0] amt_q;
  logic             accept_win;
  logic             grant0;
  logic             grant1;
  logic             accept;

  // The shifter always sees the operand registers. They keep the last operands between ops.
  assign sh_ain = op_q;
  assign sh_bin = amt_q;

  // Arbitration, readys and next state. A tie goes to prio_q. A lone request always wins.
  always_comb begin
    accept_win = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    state_d    = state_q;

    accept_win = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    grant0     = req0_valid && (!req1_valid || !prio_q);
    grant1     = req1_valid && (!req0_valid || prio_q);
    req0_ready = accept_win && grant0;
    req1_ready = accept_win && grant1;
    accept     = req0_ready || req1_ready;

    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, round-robin pointer and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      amt_q     <= '0;
      id_q      <= 1'b0;
      prio_q    <= 1'(FIRST_PRIO);
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= req1_ready ? req1_data : req0_data;
        amt_q  <= req1_ready ? req1_amt  : req0_amt;
        id_q   <= req1_ready;
        // The requester that just won loses the next tie.
        prio_q <= req0_ready;
      end
      if (state_q == EXEC) begin
        rsp_data  <= sh_yout;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if ((state_q == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and randomized checks of the shift arbiter.
// A cycle model predicts readys, rsp_valid and shifter operands. It pushes the
// expected response on every predicted accept. A monitor pops the expected response
// on every response transfer and compares it.
module tb_shift_arbiter;

  localparam int WIDTH = 16;
  localparam int AMT_W = 5;
  localparam int FIRST_PRIO = 0;

  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_RESP = 2;

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic [AMT_W-1:0] req0_amt, req1_amt;
  logic [WIDTH-1:0] sh_ain, sh_yout, rsp_data;
  logic [AMT_W-1:0] sh_bin;
  logic             rsp_valid, rsp_ready, rsp_id;

  // Expected result for each requester's current op, set by the driver.
  logic [WIDTH-1:0] exp0, exp1;

  logic [WIDTH:0] exp_q[$];
  int total;
  int bad;

  shift_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W), .FIRST_PRIO(FIRST_PRIO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
    .sh_ain(sh_ain), .sh_bin(sh_bin), .sh_yout(sh_yout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a, input logic [AMT_W-1:0] m);
    int s;
    s = $signed(m);
    if (s >= 0) return a << s;
    else        return a >> (-s);
  endfunction

  // Behavioural stand-in for the shared shifter.
  assign sh_yout = ref_shift(sh_ain, sh_bin);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- cycle model: predicts readys/valid, pushes expectations ----------------
  int               m_state = M_IDLE;
  logic             m_prio  = 1'(FIRST_PRIO);
  logic [WIDTH-1:0] m_op    = '0;
  logic [AMT_W-1:0] m_amt   = '0;

  always @(negedge clk) begin
    logic win, g0, g1, e0, e1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_state == M_RESP});
    chk("sh_ain", {16'd0, sh_ain}, {16'd0, m_op});
    chk("sh_bin", {27'd0, sh_bin}, {27'd0, m_amt});
    win = !rst && (m_state == M_IDLE || (m_state == M_RESP && rsp_ready));
    g0  = req0_valid && (!req1_valid || !m_prio);
    g1  = req1_valid && (!req0_valid || m_prio);
    e0  = win && g0;
    e1  = win && g1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    if (rst) begin
      m_state = M_IDLE;
      m_prio  = 1'(FIRST_PRIO);
      m_op    = '0;
      m_amt   = '0;
      exp_q.delete();
    end else begin
      case (m_state)
        M_EXEC:  m_state = M_RESP;
        M_RESP:  if (rsp_ready) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
      if (e0 || e1) begin
        m_state = M_EXEC;
        m_op    = e1 ? req1_data : req0_data;
        m_amt   = e1 ? req1_amt : req0_amt;
        m_prio  = e0;
        exp_q.push_back({e1, e1 ? exp1 : exp0});
      end
    end
  end

  // ---------------- monitor: pops on each response transfer ----------------
  logic             hold_pend = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic             hold_id;

  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (!rst && hold_pend) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", {16'd0, rsp_data}, {16'd0, hold_data});
      chk("hold_id", {31'd0, rsp_id}, {31'd0, hold_id});
    end
    hold_pend = !rst && rsp_valid && !rsp_ready;
    hold_data = rsp_data;
    hold_id   = rsp_id;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, e[WIDTH-1:0]});
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[WIDTH]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                         input logic [WIDTH-1:0] e);
    if (id == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a; exp0 = e;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a; exp1 = e;
    end
  endtask

  // Hold requests until each is accepted. Gives up after a fixed number of cycles.
  task automatic wait_accepts(input int budget);
    logic a0, a1;
    int n;
    n = 0;
    while ((req0_valid || req1_valid) && n < budget) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      n++;
    end
    if (req0_valid || req1_valid) begin
      chk("accept_timeout", {30'd0, req1_valid, req0_valid}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
    chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    chk({tag, "_sh_ain"}, {16'd0, sh_ain}, 32'd0);
    chk({tag, "_sh_bin"}, {27'd0, sh_bin}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc_cnt, cyc;
    logic a0, a1;
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] a;
    total = 0;
    bad = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_amt = '0;
    req1_valid = 1'b0; req1_data = '0; req1_amt = '0;
    rsp_ready = 1'b0;
    exp0 = '0;
    exp1 = '0;
    step(3);
    rst = 1'b0;
    check_reset_outputs("por");

    // Single ops with hand-computed results.
    rsp_ready = 1'b1;
    set_req(0, 16'h00F0, 5'd4, 16'h0F00);        wait_accepts(10); step(3);
    set_req(1, 16'h00F0, 5'b11100, 16'h000F);    wait_accepts(10); step(3);
    set_req(0, 16'hFFFF, 5'b10000, 16'h0000);    wait_accepts(10); step(3);
    set_req(1, 16'h0001, 5'd15, 16'h8000);       wait_accepts(10); step(3);
    set_req(0, 16'h8001, 5'd1, 16'h0002);        wait_accepts(10); step(3);
    set_req(1, 16'h8000, 5'b11111, 16'h4000);    wait_accepts(10); step(3);
    set_req(0, 16'h1234, 5'd0, 16'h1234);        wait_accepts(10); step(3);

    // Ties with rsp_ready held high. Back-to-back accepts alternate by priority.
    for (int i = 0; i < 3; i++) begin
      set_req(0, 16'h0003, 5'd2, 16'h000C);
      set_req(1, 16'hA000, 5'b11101, 16'h1400);
      wait_accepts(12);
      step(3);
    end

    // Consumer stall: the result must hold while a pending request waits.
    rsp_ready = 1'b0;
    set_req(0, 16'h0101, 5'd8, 16'h0100);
    wait_accepts(10);
    set_req(1, 16'hF00F, 5'b11000, 16'h00F0);
    step(6);
    rsp_ready = 1'b1;
    wait_accepts(5);
    step(3);

    // Reset while in EXEC discards the op.
    set_req(0, 16'h0011, 5'd3, 16'h0088);
    wait_accepts(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_outputs("rst_exec");
    step(2);

    // Reset while in RESP discards the pending result.
    rsp_ready = 1'b0;
    set_req(1, 16'h0022, 5'd1, 16'h0044);
    wait_accepts(10);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_outputs("rst_resp");
    step(2);

    // After reset the first tie goes back to FIRST_PRIO.
    rsp_ready = 1'b1;
    set_req(0, 16'h0005, 5'd4, 16'h0050);
    set_req(1, 16'h0500, 5'b11100, 16'h0050);
    wait_accepts(12);
    step(3);

    // Random stress with expected values from the reference shift.
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 400 && cyc < 20000) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (a0) begin req0_valid = 1'b0; acc_cnt++; end
      if (a1) begin req1_valid = 1'b0; acc_cnt++; end
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        d = 16'($urandom_range(0, 65535));
        a = 5'($urandom_range(0, 31));
        set_req(0, d, a, ref_shift(d, a));
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        d = 16'($urandom_range(0, 65535));
        a = 5'($urandom_range(0, 31));
        set_req(1, d, a, ref_shift(d, a));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("stress_progress", {31'd0, acc_cnt >= 400}, 32'd1);
    wait_accepts(20);
    rsp_ready = 1'b1;
    step(4);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
